// File: rtl/io_keysw_ctrl.sv
// KEY/SW memory-mapped input controller.
// Each input group is synchronized and debounced, then exposed as a read-only
// data register and a control/status register (ready, overrun, interrupt enable).
// The interrupt request is registered.

// Two-flop synchronizer plus STABLE/SETTLING debounce FSM for one input group.
module io_keysw_debounce #(
  parameter int             W               = 4,
  parameter logic [W-1:0]   RST_VAL         = '0,
  parameter int             DEBOUNCE_CYCLES = 100000,
  parameter int             DEBOUNCE_BITS   = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic         event_o
);

  typedef enum logic {STABLE, SETTLING} state_e;

  localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [W-1:0]             sync1_q, sync2_q;
  logic [W-1:0]             stable_q, stable_d;
  logic [W-1:0]             cand_q, cand_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     event_d;

  // Synchronizer flops and debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cand_q   <= RST_VAL;
      cnt_q    <= '0;
      state_q  <= STABLE;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Next-state logic: a new level is accepted only after it has been seen
  // unchanged for the full debounce window; returning to the old level
  // mid-window drops the candidate without an event.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    event_d  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
          if (sync2_q == stable_q) begin
            state_d = STABLE;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          stable_d = cand_q;
          cnt_d    = '0;
          state_d  = STABLE;
          event_d  = 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign stable_o = stable_q;
  // The event is taken from next-state so ready rises with the new stable value.
  assign event_o  = event_d;

endmodule

module io_keysw_ctrl #(
  parameter int               DBITS           = 32,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter int               DEBOUNCE_BITS   = 17,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrData,
  input  logic             wrEn,
  input  logic             rdEn,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic             sel,
  output logic [DBITS-1:0] rdData,
  output logic             intr
);

  // Group index 0 is KEY, 1 is SW throughout the status logic.
  logic [3:0] key_stable;
  logic [9:0] sw_stable;
  logic [1:0] event_w;

  io_keysw_debounce #(
    .W              (4),
    .RST_VAL        (4'hF),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_BITS  (DEBOUNCE_BITS)
  ) u_key_db (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (KEY),
    .stable_o(key_stable),
    .event_o (event_w[0])
  );

  io_keysw_debounce #(
    .W              (10),
    .RST_VAL        (10'h000),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEBOUNCE_BITS  (DEBOUNCE_BITS)
  ) u_sw_db (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (SW),
    .stable_o(sw_stable),
    .event_o (event_w[1])
  );

  logic hit_key, hit_sw, hit_kctrl, hit_sctrl;
  assign hit_key   = (addr == ADDR_KEY);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sctrl = (addr == ADDR_SCTRL);
  assign sel       = hit_key | hit_sw | hit_kctrl | hit_sctrl;

  logic [1:0] clr_w, ctrl_wr_w;
  assign clr_w     = {rdEn & hit_sw,    rdEn & hit_key};
  assign ctrl_wr_w = {wrEn & hit_sctrl, wrEn & hit_kctrl};

  logic [1:0] ready_q, ready_d;
  logic [1:0] ovr_q, ovr_d;
  logic [1:0] ie_q, ie_d;
  logic       intr_q, intr_d;

  // Only bits 4 (IE) and 1 (overrun keep) of a control write carry meaning.
  logic unused_wrdata;
  assign unused_wrdata = ^{wrData[DBITS-1:5], wrData[3:2], wrData[0]};

  // Status registers and the interrupt request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= '0;
      ovr_q   <= '0;
      ie_q    <= '0;
      intr_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
      intr_q  <= intr_d;
    end
  end

  // Status next-state: a change event sets ready (or overrun if an unread value
  // is being replaced); a data read clears ready; an overrun set beats a clear.
  always_comb begin
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;
    for (int g = 0; g < 2; g++) begin
      if (ctrl_wr_w[g]) begin
        ie_d[g] = wrData[4];
        if (!wrData[1]) begin
          ovr_d[g] = 1'b0;
        end
      end
      if (event_w[g]) begin
        if (ready_q[g] && !clr_w[g]) begin
          ovr_d[g] = 1'b1;
        end
        ready_d[g] = 1'b1;
      end else if (clr_w[g]) begin
        ready_d[g] = 1'b0;
      end
    end
    intr_d = |(ie_d & ready_d);
  end

  assign intr = intr_q;

  logic [3:0] key_pressed;
  logic [4:0] kctrl_val, sctrl_val;
  assign key_pressed = ~key_stable;
  assign kctrl_val   = {ie_q[0], 2'b00, ovr_q[0], ready_q[0]};
  assign sctrl_val   = {ie_q[1], 2'b00, ovr_q[1], ready_q[1]};

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    rdData = '0;
    if (hit_key) begin
      rdData = DBITS'(key_pressed);
    end else if (hit_sw) begin
      rdData = DBITS'(sw_stable);
    end else if (hit_kctrl) begin
      rdData = DBITS'(kctrl_val);
    end else if (hit_sctrl) begin
      rdData = DBITS'(sctrl_val);
    end
  end

endmodule

// File: tb/tb_io_keysw_ctrl.sv
// Bench for io_keysw_ctrl with a short debounce window. A behavioural model
// tracks how long each synchronized level has persisted and derives the
// register contents; outputs are compared against it on every falling edge.
module tb_io_keysw_ctrl;

  localparam int          D       = 4;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KC    = 32'hF0000110;
  localparam logic [31:0] A_SC    = 32'hF0000114;
  localparam logic [31:0] A_UNMAP = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wrData = '0;
  logic        wrEn = 1'b0;
  logic        rdEn = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic        sel;
  logic [31:0] rdData;
  logic        intr;

  int checks = 0;
  int passed = 0;
  bit armed = 1'b0;

  io_keysw_ctrl #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(D),
    .DEBOUNCE_BITS  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wrData(wrData),
    .wrEn  (wrEn),
    .rdEn  (rdEn),
    .KEY   (KEY),
    .SW    (SW),
    .sel   (sel),
    .rdData(rdData),
    .intr  (intr)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = KEY (raw, active-low, stored in low 4 bits), 1 = SW.
  bit [9:0] m_s1 [2];
  bit [9:0] m_s2 [2];
  bit [9:0] m_stab [2];
  bit [9:0] m_runv [2];
  bit [9:0] m_in [2];
  int       m_run [2];
  bit       m_rdy [2];
  bit       m_ovr [2];
  bit       m_ie [2];
  bit       m_intr;
  bit       m_evt, m_clr, m_wr;

  // A level is accepted once the synchronized input has shown the same
  // non-stable value on D+1 consecutive clock edges.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        m_s1[g] = (g == 0) ? 10'h00F : 10'h000;
        m_s2[g] = m_s1[g];
        m_stab[g] = m_s1[g];
        m_runv[g] = '0;
        m_run[g] = 0;
        m_rdy[g] = 1'b0;
        m_ovr[g] = 1'b0;
        m_ie[g] = 1'b0;
      end
      m_intr = 1'b0;
    end else begin
      m_in[0] = {6'b0, KEY};
      m_in[1] = SW;
      for (int g = 0; g < 2; g++) begin
        m_evt = 1'b0;
        if (m_s2[g] != m_stab[g]) begin
          if (m_run[g] == 0 || m_s2[g] != m_runv[g]) begin
            m_runv[g] = m_s2[g];
            m_run[g] = 1;
          end else begin
            m_run[g]++;
          end
          if (m_run[g] == D + 1) begin
            m_stab[g] = m_s2[g];
            m_run[g] = 0;
            m_evt = 1'b1;
          end
        end else begin
          m_run[g] = 0;
        end
        m_s2[g] = m_s1[g];
        m_s1[g] = m_in[g];
        m_clr = rdEn && (addr == ((g == 0) ? A_KEY : A_SW));
        m_wr  = wrEn && (addr == ((g == 0) ? A_KC : A_SC));
        if (m_wr) begin
          m_ie[g] = wrData[4];
          if (!wrData[1]) m_ovr[g] = 1'b0;
        end
        if (m_evt) begin
          if (m_rdy[g] && !m_clr) m_ovr[g] = 1'b1;
          m_rdy[g] = 1'b1;
        end else if (m_clr) begin
          m_rdy[g] = 1'b0;
        end
      end
      m_intr = (m_ie[0] && m_rdy[0]) || (m_ie[1] && m_rdy[1]);
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == A_KEY) return {28'b0, ~m_stab[0][3:0]};
    if (a == A_SW)  return {22'b0, m_stab[1]};
    if (a == A_KC)  return {27'b0, m_ie[0], 2'b00, m_ovr[0], m_rdy[0]};
    if (a == A_SC)  return {27'b0, m_ie[1], 2'b00, m_ovr[1], m_rdy[1]};
    return 32'h0;
  endfunction

  function automatic logic exp_sel(input logic [31:0] a);
    return (a == A_KEY) || (a == A_SW) || (a == A_KC) || (a == A_SC);
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_sel", {31'b0, sel}, {31'b0, exp_sel(addr)});
      chk("cyc_rdData", rdData, exp_rd(addr));
      chk("cyc_intr", {31'b0, intr}, {31'b0, m_intr});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdData, exp);
  endtask

  task automatic bus_read(input logic [31:0] a);
    addr = a;
    rdEn = 1'b1;
    cyc(1);
    rdEn = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wrData = d;
    wrEn = 1'b1;
    cyc(1);
    wrEn = 1'b0;
  endtask

  int  lat;
  bit  got;

  initial begin
    #3 reset = 1'b1;
    #1 armed = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Reset values
    expect_reg("rst_key", A_KEY, 32'h0);
    expect_reg("rst_sw", A_SW, 32'h0);
    expect_reg("rst_kctrl", A_KC, 32'h0);
    expect_reg("rst_sctrl", A_SC, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    addr = A_KC; #1;
    chk("sel_mapped", {31'b0, sel}, 32'h1);
    addr = A_UNMAP; #1;
    chk("sel_unmapped", {31'b0, sel}, 32'h0);
    chk("rd_unmapped", rdData, 32'h0);

    // SW debounce latency: new value appears after edge N+6
    SW = 10'h2A5;
    cyc(6);
    expect_reg("sw_before", A_SW, 32'h0);
    cyc(1);
    expect_reg("sw_after", A_SW, 32'h2A5);
    expect_reg("sctrl_ready", A_SC, 32'h1);
    bus_read(A_SW);
    expect_reg("sctrl_cleared", A_SC, 32'h0);

    // KEY glitch shorter than the debounce window
    KEY = 4'hE;
    cyc(3);
    KEY = 4'hF;
    cyc(10);
    expect_reg("glitch_key", A_KEY, 32'h0);
    expect_reg("glitch_kctrl", A_KC, 32'h0);

    // Two changes without a read -> overrun; clear overrun; read clears ready
    SW = 10'h155;
    cyc(7);
    expect_reg("sw_first", A_SC, 32'h1);
    SW = 10'h0F0;
    cyc(7);
    expect_reg("sw_overrun", A_SC, 32'h3);
    expect_reg("sw_second", A_SW, 32'h0F0);
    bus_write(A_SC, 32'h0);
    expect_reg("ovr_clear", A_SC, 32'h1);
    bus_write(A_SW, 32'h3FF);
    expect_reg("sw_wr_ignored", A_SW, 32'h0F0);
    bus_read(A_SW);
    expect_reg("sw_read_clr", A_SC, 32'h0);

    // Interrupt enable and KEY press
    bus_write(A_KC, 32'h10);
    expect_reg("kctrl_ie", A_KC, 32'h10);
    KEY = 4'hB;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      cyc(1);
      addr = A_KC;
      #1;
      if (rdData[0]) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("key_latency", lat, 7);
    chk("intr_set", {31'b0, intr}, 32'h1);
    expect_reg("key_pressed", A_KEY, 32'h4);
    expect_reg("kctrl_ie_ready", A_KC, 32'h11);
    bus_read(A_KEY);
    chk("intr_cleared", {31'b0, intr}, 32'h0);
    expect_reg("kctrl_after_read", A_KC, 32'h10);

    // Read coinciding with a change event while ready is already 1
    KEY = 4'hF;
    cyc(7);
    expect_reg("key_release", A_KEY, 32'h0);
    expect_reg("kctrl_rel_ready", A_KC, 32'h11);
    KEY = 4'hE;
    cyc(6);
    addr = A_KEY;
    rdEn = 1'b1;
    #1;
    chk("coincide_old_data", rdData, 32'h0);
    cyc(1);
    rdEn = 1'b0;
    expect_reg("coincide_kctrl", A_KC, 32'h11);
    expect_reg("coincide_key", A_KEY, 32'h1);

    // Asynchronous reset in the middle of a settling window
    KEY = 4'hF;
    SW = 10'h000;
    cyc(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_intr", {31'b0, intr}, 32'h0);
    expect_reg("arst_key", A_KEY, 32'h0);
    expect_reg("arst_sw", A_SW, 32'h0);
    expect_reg("arst_kctrl", A_KC, 32'h0);
    expect_reg("arst_sctrl", A_SC, 32'h0);
    cyc(2);
    reset = 1'b0;
    cyc(12);
    expect_reg("post_rst_key", A_KEY, 32'h0);
    expect_reg("post_rst_kctrl", A_KC, 32'h0);

    armed = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
